// File: rtl/pipeline_top.sv
// pipeline_top: 5-stage in-order RV32I-subset CPU (IF, ID, EX, MEM, WB).
// Build option: define FORWARDING_EN to forward EX operands from EX/MEM and
// MEM/WB. Without it, ID stalls until every producer has reached WB.

package pipeline_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_re;
    logic    use_imm;
    logic    branch;
    logic    bne;
    logic    jal;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t       CTRL_NOP  = '0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_LW  = 7'b0000011;
  localparam logic [6:0]  OP_SW  = 7'b0100011;
  localparam logic [6:0]  OP_BR  = 7'b1100011;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
endpackage

module pc_reg #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] OUT
);
  logic [XLEN-1:0] pc_q;

  // Program counter register, next value chosen by the top level.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  assign OUT = pc_q;
endmodule

module ram_array #(parameter int DEPTH = 256, parameter int AW = $clog2(DEPTH)) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] RAM_matrix [DEPTH];

  // Synchronous write port.
  // NOTE: the array has no reset; contents survive reset and are preloaded externally.
  always_ff @(posedge clk) begin
    if (we) RAM_matrix[addr] <= wdata;
  end

  assign rdata = RAM_matrix[addr];
endmodule

module mem_block #(parameter int DEPTH = 256, parameter int AW = $clog2(DEPTH)) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  ram_array #(.DEPTH(DEPTH), .AW(AW)) sub1 (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
endmodule

module reg_file #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] register_bank [32];

  // Write port from WB; x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) register_bank[i] <= '0;
    end else if (we && wa != 5'd0) begin
      register_bank[wa] <= wd;
    end
  end

  // Read ports with x0 forced to zero and a same-cycle WB bypass.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    rd1 = register_bank[ra1];
    rd2 = register_bank[ra2];
    if (ra1 == 5'd0)            rd1 = '0;
    else if (we && wa == ra1)   rd1 = wd;
    if (ra2 == 5'd0)            rd2 = '0;
    else if (we && wa == ra2)   rd2 = wd;
  end
endmodule

module pipeline_top import pipeline_pkg::*; #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int XLEN       = 32
) (
  input logic clk,
  input logic rst
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] pc_out, pc_d;
  logic [31:0]     instr_f;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  ctrl_t           ctrl_id, idex_ctrl_q, idex_ctrl_d;
  logic [XLEN-1:0] imm_id, rd1_id, rd2_id;
  logic            uses_rs1_id, uses_rs2_id, stall, dep_ex;
  logic [XLEN-1:0] idex_pc_q, idex_pc_d, idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [XLEN-1:0] idex_imm_q, idex_imm_d;
  logic [4:0]      idex_rd_q, idex_rd_d;
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res, ex_result, ex_target;
  logic            ex_taken;
  logic            exmem_reg_we_q, exmem_reg_we_d, exmem_mem_we_q, exmem_mem_we_d;
  logic            exmem_mem_re_q, exmem_mem_re_d;
  logic [XLEN-1:0] exmem_result_q, exmem_result_d, exmem_store_q, exmem_store_d;
  logic [4:0]      exmem_rd_q, exmem_rd_d;
  logic [31:0]     dmem_rdata;
  logic            memwb_reg_we_q, memwb_reg_we_d;
  logic [4:0]      memwb_rd_q, memwb_rd_d;
  logic [XLEN-1:0] memwb_data_q, memwb_data_d;

  // ---------------- IF ----------------
  pc_reg #(.XLEN(XLEN)) PC (.clk(clk), .rst(rst), .pc_d(pc_d), .OUT(pc_out));

  mem_block #(.DEPTH(IMEM_DEPTH), .AW(IMEM_AW)) INST_MEM (
    .clk(clk), .we(1'b0), .addr(pc_out[IMEM_AW+1:2]), .wdata(32'd0), .rdata(instr_f)
  );

  // ---------------- ID ----------------
  logic [6:0] opcode_id, funct7_id;
  logic [2:0] funct3_id;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode_id = ifid_instr_q[6:0];
  assign rd_id     = ifid_instr_q[11:7];
  assign funct3_id = ifid_instr_q[14:12];
  assign rs1_id    = ifid_instr_q[19:15];
  assign rs2_id    = ifid_instr_q[24:20];
  assign funct7_id = ifid_instr_q[31:25];
  assign imm_i = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31:20]};
  assign imm_s = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
  assign imm_b = {{(XLEN-13){ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                  ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                  ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

  // Decode the ID instruction; unsupported encodings fall through as NOP.
  always_comb begin
    ctrl_id     = CTRL_NOP;
    imm_id      = '0;
    uses_rs1_id = 1'b0;
    uses_rs2_id = 1'b0;
    case (opcode_id)
      OP_R: begin
        ctrl_id.reg_we = 1'b1;
        uses_rs1_id    = 1'b1;
        uses_rs2_id    = 1'b1;
        case ({funct7_id, funct3_id})
          {7'h00, 3'b000}: ctrl_id.alu_op = ALU_ADD;
          {7'h20, 3'b000}: ctrl_id.alu_op = ALU_SUB;
          {7'h00, 3'b111}: ctrl_id.alu_op = ALU_AND;
          {7'h00, 3'b110}: ctrl_id.alu_op = ALU_OR;
          {7'h00, 3'b100}: ctrl_id.alu_op = ALU_XOR;
          {7'h00, 3'b010}: ctrl_id.alu_op = ALU_SLT;
          default: begin
            ctrl_id     = CTRL_NOP;
            uses_rs1_id = 1'b0;
            uses_rs2_id = 1'b0;
          end
        endcase
      end
      OP_I: begin
        ctrl_id.reg_we  = 1'b1;
        ctrl_id.use_imm = 1'b1;
        uses_rs1_id     = 1'b1;
        imm_id          = imm_i;
        case (funct3_id)
          3'b000:  ctrl_id.alu_op = ALU_ADD;
          3'b111:  ctrl_id.alu_op = ALU_AND;
          3'b110:  ctrl_id.alu_op = ALU_OR;
          default: begin
            ctrl_id     = CTRL_NOP;
            uses_rs1_id = 1'b0;
          end
        endcase
      end
      OP_LW: if (funct3_id == 3'b010) begin
        ctrl_id.reg_we  = 1'b1;
        ctrl_id.mem_re  = 1'b1;
        ctrl_id.use_imm = 1'b1;
        uses_rs1_id     = 1'b1;
        imm_id          = imm_i;
      end
      OP_SW: if (funct3_id == 3'b010) begin
        ctrl_id.mem_we  = 1'b1;
        ctrl_id.use_imm = 1'b1;
        uses_rs1_id     = 1'b1;
        uses_rs2_id     = 1'b1;
        imm_id          = imm_s;
      end
      OP_BR: if (funct3_id[2:1] == 2'b00) begin
        ctrl_id.branch = 1'b1;
        ctrl_id.bne    = funct3_id[0];
        uses_rs1_id    = 1'b1;
        uses_rs2_id    = 1'b1;
        imm_id         = imm_b;
      end
      OP_JAL: begin
        ctrl_id.reg_we = 1'b1;
        ctrl_id.jal    = 1'b1;
        imm_id         = imm_j;
      end
      default: ;
    endcase
  end

  reg_file #(.XLEN(XLEN)) REGISTERS (
    .clk(clk), .rst(rst), .ra1(rs1_id), .ra2(rs2_id), .rd1(rd1_id), .rd2(rd2_id),
    .we(memwb_reg_we_q), .wa(memwb_rd_q), .wd(memwb_data_q)
  );

  // Hazard unit: the ID instruction reads a register still being produced.
  assign dep_ex = idex_ctrl_q.reg_we && idex_rd_q != 5'd0 &&
                  ((uses_rs1_id && rs1_id == idex_rd_q) || (uses_rs2_id && rs2_id == idex_rd_q));
`ifdef FORWARDING_EN
  assign stall = dep_ex && idex_ctrl_q.mem_re;
`else
  logic dep_mem;
  assign dep_mem = exmem_reg_we_q && exmem_rd_q != 5'd0 &&
                   ((uses_rs1_id && rs1_id == exmem_rd_q) || (uses_rs2_id && rs2_id == exmem_rd_q));
  assign stall = dep_ex || dep_mem;
`endif

  // ---------------- EX ----------------
`ifdef FORWARDING_EN
  logic [4:0] idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;

  // Operand forwarding: EX/MEM has priority over MEM/WB.
  always_comb begin
    op_a = idex_a_q;
    op_b = idex_b_q;
    if (exmem_reg_we_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q)      op_a = exmem_result_q;
    else if (memwb_reg_we_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs1_q) op_a = memwb_data_q;
    if (exmem_reg_we_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q)      op_b = exmem_result_q;
    else if (memwb_reg_we_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs2_q) op_b = memwb_data_q;
  end
`else
  assign op_a = idex_a_q;
  assign op_b = idex_b_q;
`endif

  // ALU; SLT compares signed.
  always_comb begin
    alu_b   = idex_ctrl_q.use_imm ? idex_imm_q : op_b;
    alu_res = op_a + alu_b;
    case (idex_ctrl_q.alu_op)
      ALU_SUB: alu_res = op_a - alu_b;
      ALU_AND: alu_res = op_a & alu_b;
      ALU_OR:  alu_res = op_a | alu_b;
      ALU_XOR: alu_res = op_a ^ alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      default: ;
    endcase
  end

  assign ex_taken  = idex_ctrl_q.jal || (idex_ctrl_q.branch && ((op_a == op_b) != idex_ctrl_q.bne));
  assign ex_target = idex_pc_q + idex_imm_q;
  assign ex_result = idex_ctrl_q.jal ? idex_pc_q + XLEN'(4) : alu_res;

  // ---------------- MEM ----------------
  mem_block #(.DEPTH(DMEM_DEPTH), .AW(DMEM_AW)) DATA_MEM (
    .clk(clk), .we(exmem_mem_we_q), .addr(exmem_result_q[DMEM_AW+1:2]),
    .wdata(exmem_store_q), .rdata(dmem_rdata)
  );

  // Next state of PC and all pipeline registers; a taken redirect outranks a stall.
  always_comb begin
    pc_d           = pc_out + XLEN'(4);
    ifid_pc_d      = pc_out;
    ifid_instr_d   = instr_f;
    idex_ctrl_d    = ctrl_id;
    idex_pc_d      = ifid_pc_q;
    idex_a_d       = rd1_id;
    idex_b_d       = rd2_id;
    idex_imm_d     = imm_id;
    idex_rd_d      = rd_id;
`ifdef FORWARDING_EN
    idex_rs1_d     = rs1_id;
    idex_rs2_d     = rs2_id;
`endif
    if (ex_taken) begin
      pc_d         = ex_target;
      ifid_instr_d = NOP_INSTR;
      idex_ctrl_d  = CTRL_NOP;
    end else if (stall) begin
      pc_d         = pc_out;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      idex_ctrl_d  = CTRL_NOP;
    end
    exmem_reg_we_d = idex_ctrl_q.reg_we;
    exmem_mem_we_d = idex_ctrl_q.mem_we;
    exmem_mem_re_d = idex_ctrl_q.mem_re;
    exmem_result_d = ex_result;
    exmem_store_d  = op_b;
    exmem_rd_d     = idex_rd_q;
    memwb_reg_we_d = exmem_reg_we_q;
    memwb_rd_d     = exmem_rd_q;
    memwb_data_d   = exmem_mem_re_q ? dmem_rdata : exmem_result_q;
  end

  // Pipeline registers; reset loads NOPs with all control cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_pc_q      <= '0;
      ifid_instr_q   <= NOP_INSTR;
      idex_ctrl_q    <= CTRL_NOP;
      idex_pc_q      <= '0;
      idex_a_q       <= '0;
      idex_b_q       <= '0;
      idex_imm_q     <= '0;
      idex_rd_q      <= '0;
`ifdef FORWARDING_EN
      idex_rs1_q     <= '0;
      idex_rs2_q     <= '0;
`endif
      exmem_reg_we_q <= 1'b0;
      exmem_mem_we_q <= 1'b0;
      exmem_mem_re_q <= 1'b0;
      exmem_result_q <= '0;
      exmem_store_q  <= '0;
      exmem_rd_q     <= '0;
      memwb_reg_we_q <= 1'b0;
      memwb_rd_q     <= '0;
      memwb_data_q   <= '0;
    end else begin
      ifid_pc_q      <= ifid_pc_d;
      ifid_instr_q   <= ifid_instr_d;
      idex_ctrl_q    <= idex_ctrl_d;
      idex_pc_q      <= idex_pc_d;
      idex_a_q       <= idex_a_d;
      idex_b_q       <= idex_b_d;
      idex_imm_q     <= idex_imm_d;
      idex_rd_q      <= idex_rd_d;
`ifdef FORWARDING_EN
      idex_rs1_q     <= idex_rs1_d;
      idex_rs2_q     <= idex_rs2_d;
`endif
      exmem_reg_we_q <= exmem_reg_we_d;
      exmem_mem_we_q <= exmem_mem_we_d;
      exmem_mem_re_q <= exmem_mem_re_d;
      exmem_result_q <= exmem_result_d;
      exmem_store_q  <= exmem_store_d;
      exmem_rd_q     <= exmem_rd_d;
      memwb_reg_we_q <= memwb_reg_we_d;
      memwb_rd_q     <= memwb_rd_d;
      memwb_data_q   <= memwb_data_d;
    end
  end
endmodule

// File: tb/tb_pipeline_top.sv
// tb_pipeline_top: directed programs with hand-computed architectural results.
module tb_pipeline_top;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] prog [$];

  pipeline_top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string prefix, input int idx, input logic [31:0] exp);
    check($sformatf("%s_x%0d", prefix, idx), dut.REGISTERS.register_bank[idx], exp);
  endtask

  // Hold the core in reset and load prog into IMEM, padding with NOPs.
  task automatic load_prog();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++)
      dut.INST_MEM.sub1.RAM_matrix[i] <= (i < prog.size()) ? prog[i] : NOP;
    #1;
  endtask

  task automatic release_and_run(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    #3 rst = 1'b0;
    #4;
    // Reset state.
    check("reset_pc", dut.PC.OUT, 32'h0);
    for (int i = 0; i < 6; i++) check_reg("reset", i, 32'h0);
    release_and_run(1);
    check("pc_after_1_cycle", dut.PC.OUT, 32'h4);

    // ALU chain with back-to-back dependencies, plus a write to x0.
    prog = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h40110233, 32'h00900013};
    load_prog();
    release_and_run(60);
    check_reg("alu", 0, 32'd0);
    check_reg("alu", 1, 32'd5);
    check_reg("alu", 2, 32'd7);
    check_reg("alu", 3, 32'd12);
    check_reg("alu", 4, 32'd2);

    // Asynchronous reset in mid-run clears PC and registers.
    rst = 1'b0;
    #1;
    check("midrun_reset_pc", dut.PC.OUT, 32'h0);
    for (int i = 1; i < 5; i++) check_reg("midrun_reset", i, 32'h0);

    // Logic ops, signed SLT both ways, ANDI/ORI with negative immediates.
    prog = '{32'hFFD00093, 32'h00600113, 32'h0020F1B3, 32'h0020E233, 32'h0020C2B3,
             32'h0020A333, 32'h001123B3, 32'h00F0F413, 32'hFF016493};
    load_prog();
    release_and_run(60);
    check_reg("logic", 1, 32'hFFFF_FFFD);
    check_reg("logic", 3, 32'h0000_0004);
    check_reg("logic", 4, 32'hFFFF_FFFF);
    check_reg("logic", 5, 32'hFFFF_FFFB);
    check_reg("logic", 6, 32'h0000_0001);
    check_reg("logic", 7, 32'h0000_0000);
    check_reg("logic", 8, 32'h0000_000D);
    check_reg("logic", 9, 32'hFFFF_FFF6);

    // Load-use followed by dependent store.
    prog = '{32'h00402283, 32'h005282B3, 32'h00502423};
    load_prog();
    dut.DATA_MEM.sub1.RAM_matrix[1] <= 32'h0000_002A;
    dut.DATA_MEM.sub1.RAM_matrix[2] <= 32'h0000_0000;
    #1;
    release_and_run(60);
    check_reg("ldst", 5, 32'd84);
    check("ldst_dmem2", dut.DATA_MEM.sub1.RAM_matrix[2], 32'd84);
    check("ldst_dmem1", dut.DATA_MEM.sub1.RAM_matrix[1], 32'h0000_002A);

    // Taken BEQ flushes two, BNE not taken, BNE taken.
    prog = '{32'h00100093, 32'h00108663, 32'h00900113, 32'h00900193, 32'h00300213,
             32'h00109463, 32'h00200293, 32'h00009463, 32'h00700313, 32'h00800393};
    load_prog();
    release_and_run(60);
    check_reg("br", 1, 32'd1);
    check_reg("br", 2, 32'd0);
    check_reg("br", 3, 32'd0);
    check_reg("br", 4, 32'd3);
    check_reg("br", 5, 32'd2);
    check_reg("br", 6, 32'd0);
    check_reg("br", 7, 32'd8);

    // JAL at 0x10 with +8: link 0x14, refetch at 0x18 after redirect.
    prog = '{NOP, NOP, NOP, NOP, 32'h008000EF, 32'h00900113, 32'h00400193};
    load_prog();
    release_and_run(7);
    check("jal_redirect_pc", dut.PC.OUT, 32'h18);
    run(1);
    check("jal_next_pc", dut.PC.OUT, 32'h1C);
    run(40);
    check_reg("jal", 1, 32'h14);
    check_reg("jal", 2, 32'h0);
    check_reg("jal", 3, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
